sdram_rom_arbiter: RTL and testbench
====================================

Name: sdram_rom_arbiter

Overview:
- Parametrised N-channel successor to the fixed five-ROM SDRAM front end.
- Arbitrates read requests from NUM_CH ROM segment caches onto one 32-bit SDRAM controller port, with one transaction outstanding.
- Owns the ioctl download path, which packs bytes into 32-bit words.
- Adds a round-robin mode, a download-safe drain, and a read-timeout watchdog.

Parameters:
- NUM_CH, 5: number of read channels; index 0 has highest fixed priority.
- ADDR_W, 23: SDRAM word address width.
- RR_MODE, 0: 0 = fixed priority; 1 = round-robin starting after the last granted channel.
- TIMEOUT, 255: cycles in WAIT_VALID before abort; 0 disables the watchdog.
- DL_INDEX, 0: ioctl_index value whose bytes are written to SDRAM.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ch_req  in  NUM_CH  per-channel read request; held until ch_ack
- ch_addr  in  NUM_CH*ADDR_W  flattened word addresses; channel i at [i*ADDR_W +: ADDR_W]
- ch_ack  out  NUM_CH  one-hot; request accepted by SDRAM
- ch_valid  out  NUM_CH  one-hot; sdram_q holds the granted channel's data this cycle
- ioctl_download  in  1  download active
- ioctl_wr  in  1  byte strobe
- ioctl_addr  in  25  byte address
- ioctl_data  in  8  byte
- ioctl_index  in  16  download index
- sdram_addr  out  ADDR_W  request address
- sdram_data  out  32  write data
- sdram_we  out  1  write enable
- sdram_req  out  1  request, held until sdram_ack
- sdram_ack  in  1  request accepted
- sdram_valid  in  1  read data valid
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, packer cleared.
- All outputs are registered except ch_ack and ch_valid, which are combinational gates of sdram_ack and sdram_valid with the registered grant.

State machine (IDLE, WAIT_ACK, WAIT_VALID, DL_IDLE, DL_WAIT_ACK):
- IDLE, ioctl_download=1: go to DL_IDLE. Download wins over any pending ch_req.
- IDLE, any ch_req:
  - Latch grant: lowest set index if RR_MODE=0; otherwise first set index at or after rr_ptr, modulo NUM_CH.
  - Latch sdram_addr from the granted channel; next cycle sdram_req=1, sdram_we=0.
  - Go to WAIT_ACK. Latency from ch_req to sdram_req is 1 cycle.
- WAIT_ACK:
  - Hold sdram_req and sdram_addr.
  - On sdram_ack: ch_ack[grant]=1 the same cycle, sdram_req=0 next cycle, go to WAIT_VALID.
  - The grant does not change even if a higher-priority ch_req rises.
- WAIT_VALID:
  - On sdram_valid: ch_valid[grant]=1 the same cycle; rr_ptr <= grant+1 (wraps to 0 at NUM_CH); go to IDLE.
  - Next grant is possible on the following cycle, so there is 1 idle cycle between transactions.
  - sdram_valid in the same cycle as sdram_ack in WAIT_ACK: ack and valid are both routed and the FSM goes straight to IDLE.
- Watchdog:
  - Counter clears on entry to WAIT_VALID.
  - If TIMEOUT≠0 and the count reaches TIMEOUT: timeout_err pulses, FSM goes to IDLE with no ch_valid.
  - A late sdram_valid in IDLE routes to nobody.
- Download during a read: ioctl_download rising in WAIT_ACK or WAIT_VALID does not abort. The read completes, then IDLE→DL_IDLE. Bytes arriving meanwhile are packed normally.
- Packer:
  - Accepts ioctl_wr & ioctl_download & (ioctl_index==DL_INDEX).
  - Byte goes to lane ioctl_addr[1:0], little-endian: lane 0 = [7:0].
  - The write to lane 3 marks the word complete; word address = ioctl_addr[24:2].
- DL_IDLE, word complete: sdram_data, sdram_addr and sdram_we=1 registered; sdram_req=1; go to DL_WAIT_ACK.
- DL_WAIT_ACK:
  - On sdram_ack: sdram_req=0 and sdram_we=0, go to DL_IDLE.
  - A lane-0 byte arriving before ack goes into a second holding word. The ioctl host spaces writes ≥4 cycles, so a third word never arrives.
- Download end: ioctl_download falling in DL_IDLE returns to IDLE. A partial word (lane 3 never written) is discarded and the packer cleared.
- Reset mid-operation: FSM returns to IDLE the next cycle and sdram_req drops. An in-flight sdram_valid is not routed.
- ch_ack/ch_valid are never asserted while state is DL_*.

Decomposition:
- Package rom_arb_pkg holds:
  - state encoding localparams (IDLE=0 … DL_WAIT_ACK=4);
  - the ROM channel index constants (PROG_ROM_1=0, PROG_ROM_2=1, SOUND_ROM_1=2, TILE_ROM=3, SPRITE_ROM=4) used by the top level.
- Sub-module download_packer handles the byte-lane assembly, 2-entry word holding and clear-on-download-end. Its outputs are word, word_addr, word_valid; its input is word_taken.

Test Plan:
- Fixed priority: ch_req=5'b10100 at once, ack 2 cycles after sdram_req, valid 3 cycles after ack → channel 2 served first (ch_ack[2], then ch_valid[2]), then channel 4; sdram_addr matches ch_addr[2] then ch_addr[4].
- RR_MODE=1, all 5 channels requesting continuously for 10 grants → grant order 0,1,2,3,4,0,1,2,3,4.
- Download of 8 bytes 0x11..0x88 at addresses 0..7, index 0 → two writes: addr 0 data 0x44332211, addr 1 data 0x88776655, sdram_we=1. Same bytes with index 1 → no sdram_req.
- ioctl_download rises while in WAIT_VALID for channel 1 → ch_valid[1] still pulses, then download writes proceed; 3-byte tail at download end → no write issued.
- TIMEOUT=8, no sdram_valid after ack → timeout_err pulses at the 8th WAIT_VALID cycle, FSM in IDLE; a late valid produces ch_valid=0.
- reset asserted 1 cycle after sdram_req → next cycle sdram_req=0 and all outputs 0; a subsequent sdram_valid routes nowhere.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared state encoding and channel constants for the SDRAM ROM arbiter
//
// Contents:
//   state_t          arbiter FSM states (IDLE=0 .. DL_WAIT_ACK=4)
//   PROG_ROM_1 ..    ROM channel indices, index 0 has the highest fixed priority
//   NUM_ROM_CH       number of ROM channels in the classic five-ROM layout
//   IOCTL_ADDR_W     ioctl byte address width
//   WORD_ADDR_W      32-bit word address width derived from the byte address

package rom_arb_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_ACK    = 3'd1,
        WAIT_VALID  = 3'd2,
        DL_IDLE     = 3'd3,
        DL_WAIT_ACK = 3'd4
    } state_t;

    localparam int PROG_ROM_1  = 0;
    localparam int PROG_ROM_2  = 1;
    localparam int SOUND_ROM_1 = 2;
    localparam int TILE_ROM    = 3;
    localparam int SPRITE_ROM  = 4;

    localparam int NUM_ROM_CH   = SPRITE_ROM + 1;
    localparam int IOCTL_ADDR_W = 25;
    localparam int WORD_ADDR_W  = IOCTL_ADDR_W - 2;

endpackage

// File: rtl/download_packer.sv
// rtl/download_packer.sv - packs ioctl download bytes into 32-bit SDRAM words
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   download          ioctl download active; falling clears any partial word
//   wr, addr, data    ioctl byte strobe, byte address, byte value
//   index             ioctl download index; only DL_INDEX is accepted
//   word_taken        pulse: the oldest complete word has been consumed
//   word              oldest complete word (lane 0 in [7:0])
//   word_addr         its word address (byte address [24:2])
//   word_valid        a complete word is waiting

module download_packer
    import rom_arb_pkg::*;
#(
    parameter int DL_INDEX = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    download,
    input  logic                    wr,
    input  logic [IOCTL_ADDR_W-1:0] addr,
    input  logic [7:0]              data,
    input  logic [15:0]             index,
    input  logic                    word_taken,
    output logic [31:0]             word,
    output logic [WORD_ADDR_W-1:0]  word_addr,
    output logic                    word_valid
);

    // Two holding words used as a tiny ring: bytes assemble in place in the
    // entry selected by wsel, the SDRAM side reads the entry selected by rsel.
    // The host spaces its writes, so at most one word is in flight to SDRAM
    // while the next one assembles.
    logic [31:0]            hold_data [2];
    logic [WORD_ADDR_W-1:0] hold_addr [2];
    logic [1:0]             full;
    logic                   wsel;
    logic                   rsel;
    logic                   accept;
    logic [1:0]             lane;

    assign accept = wr && download && (index == 16'(DL_INDEX));
    assign lane   = addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data[0] <= '0;
            hold_data[1] <= '0;
            hold_addr[0] <= '0;
            hold_addr[1] <= '0;
            full         <= '0;
            wsel         <= 1'b0;
            rsel         <= 1'b0;
        end else begin
            if (word_taken) begin
                full[rsel] <= 1'b0;
                rsel       <= ~rsel;
            end
            if (accept) begin
                // Lane 0 starts a fresh word, so stale upper lanes never leak.
                if (lane == 2'd0) begin
                    hold_data[wsel] <= {24'h0, data};
                end else begin
                    hold_data[wsel][{lane, 3'b000} +: 8] <= data;
                end
                if (lane == 2'd3) begin
                    full[wsel]      <= 1'b1;
                    hold_addr[wsel] <= addr[IOCTL_ADDR_W-1:2];
                    wsel            <= ~wsel;
                end
            end else if (!download) begin
                // Download ended mid-word: drop the partial bytes. Complete
                // words stay queued so the arbiter can still write them.
                hold_data[wsel] <= '0;
            end
        end
    end

    assign word       = hold_data[rsel];
    assign word_addr  = hold_addr[rsel];
    assign word_valid = full[rsel];

endmodule

// File: rtl/sdram_rom_arbiter.sv
// rtl/sdram_rom_arbiter.sv - N-channel ROM read arbiter and ioctl download writer for one SDRAM port
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   ch_req / ch_addr           per-channel read request and flattened word addresses
//   ch_ack / ch_valid          one-hot accept / data-valid strobes for the granted channel
//   ioctl_download, ioctl_wr,
//   ioctl_addr, ioctl_data,
//   ioctl_index                ioctl byte download interface
//   sdram_addr, sdram_data,
//   sdram_we, sdram_req        registered SDRAM controller request
//   sdram_ack, sdram_valid     SDRAM controller accept and read-data valid
//   timeout_err                one-cycle pulse when a read is abandoned by the watchdog

module sdram_rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_CH   = NUM_ROM_CH,
    parameter int ADDR_W   = 23,
    parameter int RR_MODE  = 0,
    parameter int TIMEOUT  = 255,
    parameter int DL_INDEX = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_valid,
    input  logic                     ioctl_download,
    input  logic                     ioctl_wr,
    input  logic [IOCTL_ADDR_W-1:0]  ioctl_addr,
    input  logic [7:0]               ioctl_data,
    input  logic [15:0]              ioctl_index,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic [31:0]              sdram_data,
    output logic                     sdram_we,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    input  logic                     sdram_valid,
    output logic                     timeout_err
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t                 state;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          next_grant;
    logic [GW-1:0]          grant_inc;
    logic                   any_req;
    int                     pick_idx;
    logic [CW-1:0]          wd_cnt;
    logic [ADDR_W-1:0]      addr_arr [NUM_CH];
    logic [NUM_CH-1:0]      grant_oh;

    logic [31:0]            pk_word;
    logic [WORD_ADDR_W-1:0] pk_addr;
    logic                   pk_valid;
    logic                   pk_taken;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            addr_arr[i] = ch_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Request picker. In round-robin mode the scan starts at rr_ptr and
    // wraps, otherwise it starts at channel 0 (fixed priority).
    always_comb begin
        next_grant = '0;
        any_req    = 1'b0;
        pick_idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            pick_idx = (RR_MODE != 0) ? int'(rr_ptr) + k : k;
            if (pick_idx >= NUM_CH) begin
                pick_idx = pick_idx - NUM_CH;
            end
            if (!any_req && ch_req[pick_idx]) begin
                any_req    = 1'b1;
                next_grant = pick_idx[GW-1:0];
            end
        end
    end

    assign grant_inc = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            grant_oh[i] = (int'(grant) == i);
        end
    end

    // ch_ack/ch_valid are the only unregistered outputs: they simply steer
    // the controller's strobes to the registered grant. Download states and
    // IDLE route nothing, which also drops late or stale sdram_valid pulses.
    assign ch_ack   = (!reset && state == WAIT_ACK && sdram_ack) ? grant_oh : '0;
    assign ch_valid = (!reset && sdram_valid &&
                       (state == WAIT_VALID || (state == WAIT_ACK && sdram_ack)))
                      ? grant_oh : '0;

    assign pk_taken = (state == DL_IDLE) && pk_valid;

    download_packer #(
        .DL_INDEX(DL_INDEX)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .download   (ioctl_download),
        .wr         (ioctl_wr),
        .addr       (ioctl_addr),
        .data       (ioctl_data),
        .index      (ioctl_index),
        .word_taken (pk_taken),
        .word       (pk_word),
        .word_addr  (pk_addr),
        .word_valid (pk_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
            sdram_addr  <= '0;
            sdram_data  <= '0;
            sdram_we    <= 1'b0;
            sdram_req   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Download has priority over pending reads.
                    if (ioctl_download) begin
                        state <= DL_IDLE;
                    end else if (any_req) begin
                        grant      <= next_grant;
                        sdram_addr <= addr_arr[next_grant];
                        sdram_we   <= 1'b0;
                        sdram_req  <= 1'b1;
                        state      <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        wd_cnt    <= '0;
                        // Controller may return data in the accept cycle.
                        if (sdram_valid) begin
                            rr_ptr <= grant_inc;
                            state  <= IDLE;
                        end else begin
                            state <= WAIT_VALID;
                        end
                    end
                end

                WAIT_VALID: begin
                    if (sdram_valid) begin
                        rr_ptr <= grant_inc;
                        state  <= IDLE;
                    end else if (TIMEOUT != 0 && int'(wd_cnt) == TIMEOUT - 1) begin
                        // Give up after TIMEOUT cycles so a lost response
                        // cannot lock out every channel.
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                DL_IDLE: begin
                    // A completed word is flushed before honouring download end.
                    if (pk_valid) begin
                        sdram_data <= pk_word;
                        sdram_addr <= ADDR_W'(pk_addr);
                        sdram_we   <= 1'b1;
                        sdram_req  <= 1'b1;
                        state      <= DL_WAIT_ACK;
                    end else if (!ioctl_download) begin
                        state <= IDLE;
                    end
                end

                DL_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        sdram_we  <= 1'b0;
                        state     <= DL_IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// tb/tb_sdram_rom_arbiter.sv - directed self-checking bench for sdram_rom_arbiter

module tb_sdram_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int NCH = 5;
    localparam int AW  = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_ack;
    logic [NCH-1:0]    ch_valid;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_data;
    logic [15:0]       ioctl_index;
    logic [AW-1:0]     sdram_addr;
    logic [31:0]       sdram_data;
    logic              sdram_we;
    logic              sdram_req;
    logic              sdram_ack;
    logic              sdram_valid;
    logic              timeout_err;

    logic [NCH-1:0]    rr_ch_req;
    logic [NCH-1:0]    rr_ch_ack;
    logic [NCH-1:0]    rr_ch_valid;
    logic [AW-1:0]     rr_sdram_addr;
    logic [31:0]       rr_sdram_data;
    logic              rr_sdram_we;
    logic              rr_sdram_req;
    logic              rr_sdram_ack;
    logic              rr_sdram_valid;
    logic              rr_timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [AW-1:0] addr_tab [NCH];

    sdram_rom_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .RR_MODE(0), .TIMEOUT(8), .DL_INDEX(0)
    ) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr),
        .ch_ack(ch_ack), .ch_valid(ch_valid),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_index(ioctl_index),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
        .timeout_err(timeout_err)
    );

    sdram_rom_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .RR_MODE(1), .TIMEOUT(8), .DL_INDEX(0)
    ) dut_rr (
        .clk(clk), .reset(reset), .ch_req(rr_ch_req), .ch_addr(ch_addr),
        .ch_ack(rr_ch_ack), .ch_valid(rr_ch_valid),
        .ioctl_download(1'b0), .ioctl_wr(1'b0),
        .ioctl_addr(25'd0), .ioctl_data(8'd0), .ioctl_index(16'd0),
        .sdram_addr(rr_sdram_addr), .sdram_data(rr_sdram_data), .sdram_we(rr_sdram_we),
        .sdram_req(rr_sdram_req), .sdram_ack(rr_sdram_ack), .sdram_valid(rr_sdram_valid),
        .timeout_err(rr_timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(sdram_req), 64'd1);
    endtask

    task automatic ack_write();
        sdram_ack = 1'b1;
        settle();
        chk("dl_no_ch_ack", 64'(ch_ack), 64'd0);
        tick();
        sdram_ack = 1'b0;
        settle();
        chk("dl_req_drop", 64'(sdram_req), 64'd0);
        chk("dl_we_drop", 64'(sdram_we), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int seen;
        reset          = 1'b1;
        ch_req         = '0;
        rr_ch_req      = '0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        ioctl_index    = '0;
        sdram_ack      = 1'b0;
        sdram_valid    = 1'b0;
        rr_sdram_ack   = 1'b0;
        rr_sdram_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            addr_tab[i] = AW'(32'h10000 * (i + 1) + i);
            ch_addr[i*AW +: AW] = addr_tab[i];
        end
        repeat (3) tick();

        // Reset state
        chk("rst_req", 64'(sdram_req), 64'd0);
        chk("rst_we", 64'(sdram_we), 64'd0);
        chk("rst_addr", 64'(sdram_addr), 64'd0);
        chk("rst_data", 64'(sdram_data), 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);
        chk("rst_ch_ack", 64'(ch_ack), 64'd0);
        chk("rst_ch_valid", 64'(ch_valid), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        reset = 1'b0;
        tick();

        // Fixed priority: channels 2 and 4 together, 2 wins
        ch_req = 5'b10100;
        tick();
        chk("fp_req2", 64'(sdram_req), 64'd1);
        chk("fp_addr2", 64'(sdram_addr), 64'(addr_tab[2]));
        chk("fp_we2", 64'(sdram_we), 64'd0);
        tick();
        tick();
        sdram_ack = 1'b1;
        settle();
        chk("fp_ack2", 64'(ch_ack), 64'b00100);
        chk("fp_noval2", 64'(ch_valid), 64'd0);
        tick();
        sdram_ack = 1'b0;
        ch_req    = 5'b10000;
        settle();
        chk("fp_req_drop", 64'(sdram_req), 64'd0);
        tick();
        tick();
        sdram_valid = 1'b1;
        settle();
        chk("fp_valid2", 64'(ch_valid), 64'b00100);
        tick();
        sdram_valid = 1'b0;
        settle();
        chk("fp_idle_gap", 64'(sdram_req), 64'd0);
        tick();
        chk("fp_req4", 64'(sdram_req), 64'd1);
        chk("fp_addr4", 64'(sdram_addr), 64'(addr_tab[4]));
        tick();
        tick();
        sdram_ack = 1'b1;
        settle();
        chk("fp_ack4", 64'(ch_ack), 64'b10000);
        tick();
        sdram_ack = 1'b0;
        ch_req    = '0;
        tick();
        tick();
        sdram_valid = 1'b1;
        settle();
        chk("fp_valid4", 64'(ch_valid), 64'b10000);
        tick();
        sdram_valid = 1'b0;
        tick();

        // Round-robin: all channels requesting, 10 grants; last one has ack+valid together
        rr_ch_req = 5'b11111;
        for (int g = 0; g < 10; g++) begin
            int n;
            int e;
            e = g % NCH;
            n = 0;
            while (!rr_sdram_req && n < 20) begin
                tick();
                n++;
            end
            chk("rr_req", 64'(rr_sdram_req), 64'd1);
            chk("rr_addr", 64'(rr_sdram_addr), 64'(addr_tab[e]));
            rr_sdram_ack = 1'b1;
            if (g == 9) rr_sdram_valid = 1'b1;
            settle();
            chk("rr_ack", 64'(rr_ch_ack), 64'(1 << e));
            if (g == 9) chk("rr_ack_valid_same", 64'(rr_ch_valid), 64'(1 << e));
            tick();
            rr_sdram_ack = 1'b0;
            if (g != 9) begin
                rr_sdram_valid = 1'b1;
                settle();
                chk("rr_valid", 64'(rr_ch_valid), 64'(1 << e));
                tick();
            end
            rr_sdram_valid = 1'b0;
        end
        settle();
        chk("rr_direct_idle", 64'(rr_sdram_req), 64'd0);
        tick();
        chk("rr_wrap_req", 64'(rr_sdram_req), 64'd1);
        chk("rr_wrap_addr", 64'(rr_sdram_addr), 64'(addr_tab[0]));
        rr_sdram_ack = 1'b1;
        tick();
        rr_sdram_ack   = 1'b0;
        rr_sdram_valid = 1'b1;
        rr_ch_req      = '0;
        tick();
        rr_sdram_valid = 1'b0;
        tick();

        // Download of 8 bytes at index 0
        ioctl_index    = 16'd0;
        ioctl_download = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) put_byte(25'(b), 8'(17 * (b + 1)));
        wait_req("dl_req0");
        chk("dl_addr0", 64'(sdram_addr), 64'd0);
        chk("dl_data0", 64'(sdram_data), 64'h44332211);
        chk("dl_we0", 64'(sdram_we), 64'd1);
        ack_write();
        for (int b = 4; b < 8; b++) put_byte(25'(b), 8'(17 * (b + 1)));
        wait_req("dl_req1");
        chk("dl_addr1", 64'(sdram_addr), 64'd1);
        chk("dl_data1", 64'(sdram_data), 64'h88776655);
        chk("dl_we1", 64'(sdram_we), 64'd1);
        ack_write();
        ioctl_download = 1'b0;
        tick();
        tick();

        // Same bytes with index 1: nothing written
        ioctl_index    = 16'd1;
        ioctl_download = 1'b1;
        tick();
        seen = 0;
        for (int b = 0; b < 8; b++) begin
            ioctl_addr = 25'(b);
            ioctl_data = 8'(17 * (b + 1));
            ioctl_wr   = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tick();
                ioctl_wr = 1'b0;
                if (sdram_req) seen = 1;
            end
        end
        chk("dl_idx1_noreq", 64'(seen), 64'd0);
        ioctl_download = 1'b0;
        ioctl_index    = 16'd0;
        tick();
        tick();

        // Download rises while channel 1 waits for data
        ch_req = 5'b00010;
        tick();
        chk("mix_req1", 64'(sdram_req), 64'd1);
        chk("mix_addr1", 64'(sdram_addr), 64'(addr_tab[1]));
        sdram_ack = 1'b1;
        settle();
        chk("mix_ack1", 64'(ch_ack), 64'b00010);
        tick();
        sdram_ack      = 1'b0;
        ch_req         = '0;
        ioctl_download = 1'b1;
        ioctl_addr     = 25'd8;
        ioctl_data     = 8'hA1;
        ioctl_wr       = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        sdram_valid = 1'b1;
        settle();
        chk("mix_valid1", 64'(ch_valid), 64'b00010);
        tick();
        sdram_valid = 1'b0;
        settle();
        chk("mix_idle_req", 64'(sdram_req), 64'd0);
        put_byte(25'd9, 8'hA2);
        put_byte(25'd10, 8'hA3);
        put_byte(25'd11, 8'hA4);
        wait_req("mix_dl_req");
        chk("mix_dl_addr", 64'(sdram_addr), 64'd2);
        chk("mix_dl_data", 64'(sdram_data), 64'hA4A3A2A1);
        chk("mix_dl_we", 64'(sdram_we), 64'd1);
        ack_write();

        // 3-byte tail then download end: no write, partial word discarded
        put_byte(25'd12, 8'hB1);
        put_byte(25'd13, 8'hB2);
        put_byte(25'd14, 8'hB3);
        ioctl_download = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (sdram_req) seen = 1;
        end
        chk("tail_nowrite", 64'(seen), 64'd0);
        ioctl_download = 1'b1;
        tick();
        put_byte(25'd17, 8'hC2);
        put_byte(25'd18, 8'hC3);
        put_byte(25'd19, 8'hC4);
        wait_req("clr_req");
        chk("clr_addr", 64'(sdram_addr), 64'd4);
        chk("clr_data", 64'(sdram_data), 64'hC4C3C200);
        ack_write();
        ioctl_download = 1'b0;
        tick();
        tick();

        // Watchdog: TIMEOUT=8, no data after ack
        ch_req = 5'b00001;
        tick();
        chk("wd_req", 64'(sdram_req), 64'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        ch_req    = '0;
        repeat (7) tick();
        chk("wd_no_early", 64'(timeout_err), 64'd0);
        chk("wd_still_wait", 64'(dut.state), 64'(WAIT_VALID));
        tick();
        chk("wd_pulse", 64'(timeout_err), 64'd1);
        chk("wd_state_idle", 64'(dut.state), 64'(IDLE));
        tick();
        chk("wd_pulse_end", 64'(timeout_err), 64'd0);
        sdram_valid = 1'b1;
        settle();
        chk("wd_late_valid", 64'(ch_valid), 64'd0);
        tick();
        sdram_valid = 1'b0;
        tick();

        // Reset one cycle after sdram_req
        ch_req = 5'b01000;
        tick();
        chk("rq_req", 64'(sdram_req), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        ch_req      = '0;
        sdram_valid = 1'b1;
        settle();
        chk("rq_req_drop", 64'(sdram_req), 64'd0);
        chk("rq_addr", 64'(sdram_addr), 64'd0);
        chk("rq_we", 64'(sdram_we), 64'd0);
        chk("rq_data", 64'(sdram_data), 64'd0);
        chk("rq_terr", 64'(timeout_err), 64'd0);
        chk("rq_ch_valid", 64'(ch_valid), 64'd0);
        chk("rq_ch_ack", 64'(ch_ack), 64'd0);
        tick();
        sdram_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
